// File: rtl/qpsk_pkg.sv
// qpsk_pkg: shared definitions for the coherent QPSK demodulator.
//   DW_DEF, CAR_PERIOD_DEF, SYM_LEN_DEF, ACC_W_DEF : default geometry
//                                                    (120 MHz clock, 1 MHz carrier,
//                                                    100 kHz symbols, 12-bit ADC)
//   OFFSET_ZERO : offset-binary code meaning zero; flipping its bit
//                 turns an offset-binary sample into two's complement
//   state_t     : demodulator state (IDLE, RUN)
//   ref_sign    : +1 / -1 square-wave reference for a carrier phase
package qpsk_pkg;

   localparam int DW_DEF         = 12;
   localparam int CAR_PERIOD_DEF = 120;
   localparam int SYM_LEN_DEF    = 1200;
   localparam int ACC_W_DEF      = 24;

   localparam int OFFSET_ZERO = 1 << (DW_DEF - 1);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // In-phase reference is positive over the first half carrier cycle;
   // quadrature reference is positive over the first and last quarters.
   function automatic logic signed [1:0] ref_sign(
      input int unsigned ph,
      input logic        quadrature,
      input int unsigned period = CAR_PERIOD_DEF
   );
      logic pos;
      if (quadrature) pos = (ph < period / 4) || (ph >= (3 * period) / 4);
      else            pos = (ph < period / 2);
      return pos ? 2'sb01 : 2'sb11;
   endfunction

endpackage

// File: rtl/qpsk_ref_gen.sv
// qpsk_ref_gen: carrier phase counter and square-wave I/Q references.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : current sample is carrier phase 0 (sync or idle)
//   advance    : a sample is consumed this cycle; step the phase
//   i_ref      : +1 / -1 in-phase reference for the current sample
//   q_ref      : +1 / -1 quadrature reference for the current sample
module qpsk_ref_gen import qpsk_pkg::*; #(
   parameter int CAR_PERIOD = CAR_PERIOD_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              advance,
   output logic signed [1:0] i_ref,
   output logic signed [1:0] q_ref
);

   localparam int PW = $clog2(CAR_PERIOD);

   logic [PW-1:0] ph_q;
   logic [PW-1:0] ph_cur;
   logic [PW-1:0] ph_inc;

   // clear acts on the sample of this very cycle, so the phase seen by the
   // references is forced to 0 combinationally, not one cycle later.
   assign ph_cur = clear ? '0 : ph_q;
   assign ph_inc = (ph_cur == PW'(CAR_PERIOD - 1)) ? '0 : ph_cur + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       ph_q <= '0;
      else if (advance) ph_q <= ph_inc;
      else if (clear)   ph_q <= '0;
   end

   assign i_ref = ref_sign(32'(ph_cur), 1'b0, CAR_PERIOD);
   assign q_ref = ref_sign(32'(ph_cur), 1'b1, CAR_PERIOD);

endmodule

// File: rtl/qpsk_demod.sv
// qpsk_demod: coherent QPSK demodulator, integrate-and-dump over one symbol.
//   clk, rst_n   : sample clock, asynchronous active-low reset
//   en           : enable; low forces IDLE and drops any partial symbol
//   sync_start   : current sample becomes carrier phase 0, symbol sample 0
//   din_valid    : din carries a sample this cycle
//   din          : ADC sample, offset binary
//   dout         : decided symbol, [1] = I decision, [0] = Q decision
//   dout_valid   : one-cycle strobe, dout / i_sum / q_sum just updated
//   i_sum, q_sum : signed correlations of the last completed symbol
//   busy         : high while in RUN (the FSM state itself)
//
// Handshake: a sample is consumed on every rising edge where din_valid is
// high and the block is in RUN (or is entering it through sync_start with
// en high); there is no back-pressure, and dout_valid is a pure strobe
// with no ready.
module qpsk_demod import qpsk_pkg::*; #(
   parameter int DW         = DW_DEF,
   parameter int CAR_PERIOD = CAR_PERIOD_DEF,
   parameter int SYM_LEN    = SYM_LEN_DEF,
   parameter int ACC_W      = ACC_W_DEF
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic                    sync_start,
   input  logic                    din_valid,
   input  logic [DW-1:0]           din,
   output logic [1:0]              dout,
   output logic                    dout_valid,
   output logic signed [ACC_W-1:0] i_sum,
   output logic signed [ACC_W-1:0] q_sum,
   output logic                    busy
);

   localparam int SW = $clog2(SYM_LEN);

   state_t state;
   state_t state_nxt;

   logic restart;
   logic clear;
   logic take;
   logic last;
   logic [SW-1:0] sc_q;
   logic [SW-1:0] sc_cur;
   logic signed [1:0] i_ref;
   logic signed [1:0] q_ref;
   logic i_neg;
   logic q_neg;
   logic signed [ACC_W-1:0] s;
   logic signed [ACC_W-1:0] i_acc;
   logic signed [ACC_W-1:0] q_acc;
   logic signed [ACC_W-1:0] i_base;
   logic signed [ACC_W-1:0] q_base;
   logic signed [ACC_W-1:0] i_total;
   logic signed [ACC_W-1:0] q_total;

   assign restart = en & sync_start;
   // Whenever clear is high the current sample (if any) starts from zero:
   // idle, disabled, or resynchronising.
   assign clear   = (state == IDLE) | ~en | sync_start;
   assign take    = en & din_valid & ((state == RUN) | sync_start);
   assign sc_cur  = clear ? '0 : sc_q;
   // A sync on the final sample forces sc_cur to 0, so the dump is skipped.
   assign last    = take & (sc_cur == SW'(SYM_LEN - 1));

   // Offset binary to two's complement: invert the MSB, then sign-extend.
   assign s = {{(ACC_W - DW){~din[DW-1]}}, ~din[DW-1], din[DW-2:0]};

   qpsk_ref_gen #(
      .CAR_PERIOD (CAR_PERIOD)
   ) u_ref_gen (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (clear),
      .advance (take),
      .i_ref   (i_ref),
      .q_ref   (q_ref)
   );

   assign i_neg   = (i_ref < 2'sd0);
   assign q_neg   = (q_ref < 2'sd0);
   assign i_base  = clear ? '0 : i_acc;
   assign q_base  = clear ? '0 : q_acc;
   assign i_total = i_neg ? i_base - s : i_base + s;
   assign q_total = q_neg ? q_base - s : q_base + s;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (restart) state_nxt = RUN;
         RUN:     if (!en)     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   assign busy = (state == RUN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sc_q       <= '0;
         i_acc      <= '0;
         q_acc      <= '0;
         i_sum      <= '0;
         q_sum      <= '0;
         dout       <= '0;
         dout_valid <= 1'b0;
      end else begin
         dout_valid <= 1'b0;
         if (take) begin
            if (last) begin
               sc_q       <= '0;
               i_acc      <= '0;
               q_acc      <= '0;
               i_sum      <= i_total;
               q_sum      <= q_total;
               dout       <= {~i_total[ACC_W-1], ~q_total[ACC_W-1]};
               dout_valid <= 1'b1;
            end else begin
               sc_q  <= sc_cur + 1'b1;
               i_acc <= i_total;
               q_acc <= q_total;
            end
         end else if (clear) begin
            sc_q  <= '0;
            i_acc <= '0;
            q_acc <= '0;
         end
      end
   end

endmodule

// File: tb/tb_qpsk_demod.sv
// tb_qpsk_demod: self-checking bench for qpsk_demod.
module tb_qpsk_demod;
   import qpsk_pkg::*;

   localparam int DW    = 12;
   localparam int CAR   = 120;
   localparam int SYM   = 1200;
   localparam int ACC_W = 24;
   localparam int W     = 2 + 2 * ACC_W;
   localparam real PI   = 3.14159265358979;

   // ---------------- clock / reset / DUT ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic en = 1'b0;
   logic sync_start = 1'b0;
   logic din_valid = 1'b0;
   logic [DW-1:0] din = '0;
   logic [1:0] dout;
   logic dout_valid;
   logic signed [ACC_W-1:0] i_sum;
   logic signed [ACC_W-1:0] q_sum;
   logic busy;

   always #4 clk = ~clk;

   qpsk_demod #(
      .DW         (DW),
      .CAR_PERIOD (CAR),
      .SYM_LEN    (SYM),
      .ACC_W      (ACC_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .sync_start (sync_start),
      .din_valid  (din_valid),
      .din        (din),
      .dout       (dout),
      .dout_valid (dout_valid),
      .i_sum      (i_sum),
      .q_sum      (q_sum),
      .busy       (busy)
   );

   int checks = 0;
   int errors = 0;

   // ---------------- reference model ----------------
   // Sample-indexed view: k is the position of a sample within its symbol,
   // the carrier phase is k mod CAR, sums are plain integers.
   bit         m_run;
   int         m_k;
   longint     m_i;
   longint     m_q;
   int         m_isum;
   int         m_qsum;
   logic [1:0] m_dout;
   bit         m_valid;
   logic [W-1:0] exp_q[$];

   int         dumps = 0;
   logic [1:0] cap_dout;
   int         cap_i;
   int         cap_q;

   task automatic model_reset();
      m_run = 0; m_k = 0; m_i = 0; m_q = 0;
      m_isum = 0; m_qsum = 0; m_dout = 2'b00; m_valid = 0;
      exp_q.delete();
   endtask

   task automatic model_step(input bit e, input bit sy, input bit dv, input int d);
      int smp;
      int ph;
      m_valid = 0;
      if (!e) begin
         m_run = 0; m_k = 0; m_i = 0; m_q = 0;
      end else if (sy || m_run) begin
         if (sy) begin
            m_k = 0; m_i = 0; m_q = 0;
         end
         m_run = 1;
         if (dv) begin
            smp = d - OFFSET_ZERO;
            ph  = m_k % CAR;
            m_i += (ph < CAR / 2) ? smp : -smp;
            m_q += (ph < CAR / 4 || ph >= 3 * CAR / 4) ? smp : -smp;
            if (m_k == SYM - 1) begin
               m_isum  = int'(m_i);
               m_qsum  = int'(m_q);
               m_dout  = {m_i >= 0, m_q >= 0};
               m_valid = 1;
               exp_q.push_back({m_dout, 24'(m_i), 24'(m_q)});
               m_k = 0; m_i = 0; m_q = 0;
            end else begin
               m_k++;
            end
         end
      end
   endtask

   // ---------------- scoreboard ----------------
   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_cycle();
      logic [W-1:0] exp_word;
      exp_word = '0;
      chk("dout_valid", longint'(dout_valid), longint'(m_valid));
      chk("busy", longint'(busy), longint'(m_run));
      if (m_valid && exp_q.size() > 0) exp_word = exp_q.pop_front();
      if (dout_valid) begin
         dumps++;
         cap_dout = dout;
         cap_i    = int'(i_sum);
         cap_q    = int'(q_sum);
         if (m_valid) chk("dump_word", longint'({dout, i_sum, q_sum}), longint'(exp_word));
      end
      chk("dout_hold", longint'(dout), longint'(m_dout));
      chk("i_sum", longint'(i_sum), longint'(m_isum));
      chk("q_sum", longint'(q_sum), longint'(m_qsum));
   endtask

   // ---------------- driver ----------------
   // Called at 1 time unit after a rising edge; returns at the same point of
   // the next cycle with the outputs checked.
   task automatic cycle(input bit e, input bit sy, input bit dv, input int d);
      en         = e;
      sync_start = sy;
      din_valid  = dv;
      din        = DW'(d);
      model_step(e, sy, dv, d);
      @(posedge clk);
      #1;
      check_cycle();
   endtask

   function automatic int rnd_din();
      case ($urandom_range(0, 3))
         0:       return 0;
         1:       return (1 << DW) - 1;
         default: return int'($urandom_range(0, (1 << DW) - 1));
      endcase
   endfunction

   // kind 0: square wave high when ((ph + param) mod CAR) < CAR/2
   // kind 1: constant code param
   // kind 2: sine of amplitude 2000 with phase offset param degrees
   function automatic int sample_val(input int kind, input int param, input int k);
      int ph;
      ph = k % CAR;
      case (kind)
         0:       return (((ph + param) % CAR) < CAR / 2) ? 4095 : 0;
         1:       return param;
         default: return 2048 + int'(2000.0 * $sin(2.0 * PI * real'(ph) / real'(CAR)
                                                     + real'(param) * PI / 180.0));
      endcase
   endfunction

   typedef struct {
      string      name;
      int         kind;
      int         param;
      bit         gaps;
      bit         sync;
      logic [1:0] exp_dout;
      int         exp_i;
      int         exp_q;
      bit         chk_sums;
   } vec_t;

   vec_t vecs[11];

   initial begin
      int sent;
      int c;
      int d0;
      int hold_i;
      int hold_q;
      logic [1:0] hold_d;
      bit dv;

      vecs[0]  = '{"sq_i",      0, 0,    0, 1, 2'b11,  2457000,        0, 1};
      vecs[1]  = '{"sq_i_gaps", 0, 0,    1, 1, 2'b11,  2457000,        0, 1};
      vecs[2]  = '{"sq_q",      0, 30,   0, 1, 2'b11,        0,  2457000, 1};
      vecs[3]  = '{"sq_i_inv",  0, 60,   0, 1, 2'b01, -2457000,        0, 1};
      vecs[4]  = '{"sq_q_inv",  0, 90,   0, 1, 2'b10,        0, -2457000, 1};
      vecs[5]  = '{"const_mid", 1, 2048, 0, 1, 2'b11,        0,        0, 1};
      vecs[6]  = '{"const_min", 1, 0,    0, 1, 2'b11,        0,        0, 1};
      vecs[7]  = '{"sin_45",    2, 45,   0, 1, 2'b11,        0,        0, 0};
      vecs[8]  = '{"sin_135",   2, 135,  0, 0, 2'b01,        0,        0, 0};
      vecs[9]  = '{"sin_225",   2, 225,  0, 0, 2'b00,        0,        0, 0};
      vecs[10] = '{"sin_315",   2, 315,  0, 0, 2'b10,        0,        0, 0};

      // ---------- reset and idle ----------
      model_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_dout", longint'(dout), 0);
      chk("reset_dout_valid", longint'(dout_valid), 0);
      chk("reset_i_sum", longint'(i_sum), 0);
      chk("reset_q_sum", longint'(q_sum), 0);
      chk("reset_busy", longint'(busy), 0);
      rst_n = 1'b1;
      for (int k = 0; k < 3000; k++) cycle(1, 0, $urandom_range(0, 1) == 1, rnd_din());
      chk("idle_no_dumps", dumps, 0);

      // ---------- table-driven symbols ----------
      for (int r = 0; r < 11; r++) begin
         sent = 0;
         c    = 0;
         d0   = dumps;
         while (sent < SYM) begin
            dv = !(vecs[r].gaps && (c % 3 == 2));
            cycle(1, vecs[r].sync && (c == 0), dv, sample_val(vecs[r].kind, vecs[r].param, sent));
            if (dv) sent++;
            c++;
         end
         chk({vecs[r].name, "_latency"}, longint'(dout_valid), 1);
         chk({vecs[r].name, "_dumps"}, dumps - d0, 1);
         chk({vecs[r].name, "_dout"}, longint'(cap_dout), longint'(vecs[r].exp_dout));
         if (vecs[r].chk_sums) begin
            chk({vecs[r].name, "_i_sum"}, cap_i, vecs[r].exp_i);
            chk({vecs[r].name, "_q_sum"}, cap_q, vecs[r].exp_q);
         end
      end

      // ---------- resync at sample 600 ----------
      d0 = dumps;
      for (int k = 0; k < 600; k++) cycle(1, k == 0, 1, rnd_din());
      for (int k = 0; k < SYM; k++) cycle(1, k == 0, 1, rnd_din());
      chk("resync_latency", longint'(dout_valid), 1);
      chk("resync_dumps", dumps - d0, 1);

      // ---------- sync on sample 1199 ----------
      d0 = dumps;
      for (int k = 0; k < SYM - 1; k++) cycle(1, k == 0, 1, rnd_din());
      cycle(1, 1, 1, rnd_din());
      chk("sync_last_no_strobe", longint'(dout_valid), 0);
      for (int k = 1; k < SYM - 1; k++) cycle(1, 0, 1, rnd_din());
      chk("sync_last_no_dumps", dumps - d0, 0);
      cycle(1, 0, 1, rnd_din());
      chk("sync_last_next_dump", longint'(dout_valid), 1);

      // ---------- en dropped at sample 700 ----------
      hold_i = m_isum;
      hold_q = m_qsum;
      hold_d = m_dout;
      d0 = dumps;
      for (int k = 0; k < 700; k++) cycle(1, k == 0, 1, rnd_din());
      cycle(0, 0, 1, rnd_din());
      chk("en_drop_busy", longint'(busy), 0);
      for (int k = 0; k < 20; k++) cycle(k < 10 ? 0 : 1, 0, 1, rnd_din());
      chk("en_drop_i_hold", longint'(i_sum), hold_i);
      chk("en_drop_q_hold", longint'(q_sum), hold_q);
      chk("en_drop_dout_hold", longint'(dout), longint'(hold_d));
      chk("en_drop_no_dumps", dumps - d0, 0);

      // ---------- asynchronous reset at sample 300 ----------
      for (int k = 0; k < 300; k++) cycle(1, k == 0, 1, rnd_din());
      rst_n = 1'b0;
      #1;
      chk("rst_async_dout", longint'(dout), 0);
      chk("rst_async_dout_valid", longint'(dout_valid), 0);
      chk("rst_async_i_sum", longint'(i_sum), 0);
      chk("rst_async_q_sum", longint'(q_sum), 0);
      chk("rst_async_busy", longint'(busy), 0);
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // ---------- randomized traffic against the model ----------
      for (int k = 0; k < 12000; k++) begin
         bit e;
         bit sy;
         e  = $urandom_range(0, 5999) != 0;
         sy = ($urandom_range(0, 2999) == 0) || (!m_run && $urandom_range(0, 49) == 0);
         cycle(e, sy, $urandom_range(0, 9) < 8, rnd_din());
      end
      chk("exp_q_drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
